// File: rtl/fm_deviation_loader.sv
// rtl/fm_deviation_loader.sv - assembles a 48-bit FM deviation word from host writes and
// commits it to the deviation register on a DDS update tick, with a watchdog fallback.
module fm_deviation_loader #(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TMR_W          = 16
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Wr_Strobe,
  input  logic [1:0]  Wr_Addr,
  input  logic [15:0] Wr_Data,
  input  logic        Commit,
  input  logic        Clear_Err,
  input  logic        Update_Tick,
  output logic [47:0] Dev_Data,
  output logic        Dev_EN,
  output logic        Busy,
  output logic        Err_Incomplete,
  output logic        Err_Timeout
);

  typedef enum logic [1:0] {IDLE, PENDING, LOAD} state_t;

  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t            state, state_next;
  logic [47:0]       staged, pending;
  logic [2:0]        mask, wr_sel;
  logic [TMR_W-1:0]  timer;
  logic              commit_ok, commit_bad, tick_load, timeout_load;
  logic              dev_en_next, busy_next;

  always_comb begin
    wr_sel = 3'b000;
    if (Wr_Strobe) begin
      case (Wr_Addr)
        2'd0:    wr_sel = 3'b001;
        2'd1:    wr_sel = 3'b010;
        2'd2:    wr_sel = 3'b100;
        default: wr_sel = 3'b000;
      endcase
    end
  end

  assign commit_ok    = Commit && (state != LOAD) && (mask == 3'b111);
  assign commit_bad   = Commit && (state != LOAD) && (mask != 3'b111);
  assign tick_load    = (state == PENDING) && Update_Tick;
  // A fresh commit restarts the watchdog, so it cannot also time out this cycle.
  assign timeout_load = (state == PENDING) && !Update_Tick && !commit_ok && (timer == TMO_LAST);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state  <= IDLE;
      Dev_EN <= 1'b0;
      Busy   <= 1'b0;
    end else begin
      state  <= state_next;
      Dev_EN <= dev_en_next;
      Busy   <= busy_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (commit_ok) state_next = PENDING;
      PENDING: if (tick_load || timeout_load) state_next = LOAD;
      LOAD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    dev_en_next = (state_next == LOAD);
    busy_next   = (state_next != IDLE);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      staged         <= '0;
      pending        <= '0;
      mask           <= 3'b000;
      timer          <= '0;
      Dev_Data       <= '0;
      Err_Incomplete <= 1'b0;
      Err_Timeout    <= 1'b0;
    end else begin
      if (wr_sel[0]) staged[15:0]  <= Wr_Data;
      if (wr_sel[1]) staged[31:16] <= Wr_Data;
      if (wr_sel[2]) staged[47:32] <= Wr_Data;
      // Mask clear from a commit happens first so a coincident write stays recorded.
      mask <= (commit_ok ? 3'b000 : mask) | wr_sel;
      if (commit_ok) pending <= staged;
      if (commit_ok) timer <= '0;
      else if (state == PENDING && !Update_Tick) timer <= timer + 1'b1;
      // A commit landing with the tick wins over the older pending word.
      if (tick_load || timeout_load) Dev_Data <= commit_ok ? staged : pending;
      Err_Incomplete <= commit_bad   | (Err_Incomplete & ~Clear_Err);
      Err_Timeout    <= timeout_load | (Err_Timeout & ~Clear_Err);
    end
  end

endmodule
